// File: rtl/store_align_buffer_pkg.sv
// Shared store-type codes and width helpers for the MEM-stage store path.
package store_align_buffer_pkg;

    localparam logic [3:0] STR_NONE = 4'd0;
    localparam logic [3:0] STR_SB   = 4'd1;
    localparam logic [3:0] STR_SH   = 4'd2;
    localparam logic [3:0] STR_SW   = 4'd3;
    localparam logic [3:0] STR_SWL  = 4'd4;
    localparam logic [3:0] STR_SWR  = 4'd5;
    localparam logic [3:0] STR_SC   = 4'd6;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/store_align_buffer_lane_align.sv
// Combinational store aligner: places rt into the addressed bytes of a bus word.
module store_lane_align
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          str_type,
    input  logic [1:0]          off,
    input  logic                lane,
    input  logic [31:0]         rt,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W/8-1:0] strb,
    output logic                misaligned,
    output logic                is_store
);

    logic [31:0] wdata;
    logic [3:0]  wstrb;

    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b0;
        is_store   = 1'b0;
        case (str_type)
            STR_SB: begin
                is_store = 1'b1;
                wstrb    = 4'b0001 << off;
                wdata    = {24'h0, rt[7:0]} << {off, 3'b000};
            end
            STR_SH: begin
                is_store   = 1'b1;
                misaligned = off[0];
                wstrb      = off[1] ? 4'b1100 : 4'b0011;
                wdata      = off[1] ? {rt[15:0], 16'h0} : {16'h0, rt[15:0]};
            end
            STR_SW, STR_SC: begin
                is_store   = 1'b1;
                misaligned = (off != 2'd0);
                wstrb      = 4'b1111;
                wdata      = rt;
            end
            STR_SWL: begin
                // Most-significant bytes of rt land at the low end of the word.
                is_store = 1'b1;
                wstrb    = 4'b1111 >> (2'd3 - off);
                wdata    = rt >> {(2'd3 - off), 3'b000};
            end
            STR_SWR: begin
                is_store = 1'b1;
                wstrb    = 4'b1111 << off;
                wdata    = rt << {off, 3'b000};
            end
            default: ;
        endcase
    end

    if (DATA_W == 64) begin : g_w64
        assign data = lane ? {wdata, 32'h0} : {32'h0, wdata};
        assign strb = lane ? {wstrb, 4'h0} : {4'h0, wstrb};
    end else begin : g_w32
        wire unused_lane = lane;
        assign data = wdata;
        assign strb = wstrb;
    end

endmodule

// File: rtl/store_align_buffer.sv
// Write-combining store buffer: aligns stores, merges into the youngest entry, drains in FIFO order.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [3:0]               in_type,
    input  logic [31:0]              in_data,
    input  logic                     llbit,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [DATA_W/8-1:0]      out_strb,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sc_done,
    output logic                     sc_result,
    output logic                     err
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int LSB    = $clog2(STRB_W);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int WA     = ADDR_W - LSB;

    logic [WA-1:0]     mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [STRB_W-1:0] mem_strb [DEPTH];
    logic [PW-1:0]     head, tail, young;
    logic [CW-1:0]     count_q;

    logic [DATA_W-1:0] a_data, bmask;
    logic [STRB_W-1:0] a_strb;
    logic              a_mis, a_store, lane;
    logic              accept, is_sc, push_ok, pop, hit, merge, alloc;

    assign lane = (DATA_W == 64) ? in_addr[2] : 1'b0;

    store_lane_align #(.DATA_W(DATA_W)) u_align (
        .str_type   (in_type),
        .off        (in_addr[1:0]),
        .lane       (lane),
        .rt         (in_data),
        .data       (a_data),
        .strb       (a_strb),
        .misaligned (a_mis),
        .is_store   (a_store)
    );

    assign in_ready  = (count_q < CW'(DEPTH)) & ~flush;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign is_sc     = (in_type == STR_SC);
    assign push_ok   = accept & a_store & ~a_mis & (~is_sc | llbit);
    assign young     = tail - PW'(1);

    // Never merge into the head that is leaving this cycle; that store would be lost.
    assign hit   = out_valid & (mem_addr[young] == in_addr[ADDR_W-1:LSB])
                 & ~(pop & (young == head));
    assign merge = push_ok & hit;
    assign alloc = push_ok & ~hit;

    always_comb begin
        bmask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            bmask[i*8 +: 8] = {8{a_strb[i]}};
        end
    end

    assign out_addr = out_valid ? {mem_addr[head], {LSB{1'b0}}} : '0;
    assign out_data = out_valid ? mem_data[head] : '0;
    assign out_strb = out_valid ? mem_strb[head] : '0;
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            sc_done   <= 1'b0;
            sc_result <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
                mem_strb[i] <= '0;
            end
        end else begin
            sc_done   <= accept & is_sc;
            sc_result <= accept & is_sc & llbit & ~a_mis;
            err       <= accept & a_mis;
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                count_q <= '0;
            end else begin
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (alloc) begin
                    mem_addr[tail] <= in_addr[ADDR_W-1:LSB];
                    mem_data[tail] <= a_data;
                    mem_strb[tail] <= a_strb;
                    tail           <= tail + PW'(1);
                end
                if (merge) begin
                    mem_data[young] <= (mem_data[young] & ~bmask) | (a_data & bmask);
                    mem_strb[young] <= mem_strb[young] | a_strb;
                end
                case ({alloc, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
